// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 Hz VGA raster generator.
// Default timing is the standard 25 MHz mode; totals are derived from the parts.
package vga_pkg;

  localparam int COORD_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [2:0]         color_t;
  typedef logic [COORD_W-1:0] coord_t;

  // True when val lies in [first, first+len-1]; unsigned compares only.
  function automatic logic in_span(input coord_t val, input coord_t first,
                                   input coord_t len);
    coord_t stop;
    stop = coord_t'(first + len);
    return (val >= first) && (val < stop);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the raster generator (master) and the image
// source / pads (slave). frame_tick exists only when VGA_FRAME_TICK_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t x;
  coord_t y;
  color_t color;
  logic   vga_r;
  logic   vga_g;
  logic   vga_b;
  logic   hsync;
  logic   vsync;
  logic   active;
`ifdef VGA_FRAME_TICK_EN
  logic   frame_tick;

  modport master (
    output x, y, vga_r, vga_g, vga_b, hsync, vsync, active, frame_tick,
    input  color
  );

  modport slave (
    input  x, y, vga_r, vga_g, vga_b, hsync, vsync, active, frame_tick,
    output color
  );
`else
  modport master (
    output x, y, vga_r, vga_g, vga_b, hsync, vsync, active,
    input  color
  );

  modport slave (
    input  x, y, vga_r, vga_g, vga_b, hsync, vsync, active,
    output color
  );
`endif

endinterface

// File: rtl/vga_timing_gen_raster_counter.sv
// Enabled wrap counter 0..TOTAL-1 with a terminal-count flag; used once for
// pixels within a line and once for lines within a frame.
module raster_counter #(
  parameter int TOTAL = vga_pkg::H_TOTAL,
  parameter int W     = vga_pkg::COORD_W
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign tc    = (count_reg == LAST);
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (en) begin
      count_next = tc ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: 1-based x/y to the image source, one register stage on
// RGB/sync/active so all pads align. Optional frame_tick via VGA_FRAME_TICK_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LEN   = coord_t'(H_SYNC);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LEN   = coord_t'(V_SYNC);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_tc;
  logic   v_tc;

  logic   vis;
  logic   hs_int;
  logic   vs_int;

  color_t rgb_reg;
  color_t rgb_next;
  logic   active_reg;
  logic   active_next;
  logic   hsync_reg;
  logic   hsync_next;
  logic   vsync_reg;
  logic   vsync_next;

  // Line counter free-runs; the frame counter advances only on line wrap.
  raster_counter #(
    .TOTAL (H_TOT),
    .W     (COORD_W)
  ) u_h_counter (
    .clk   (CLOCK_25),
    .srst  (reset),
    .en    (1'b1),
    .count (h_cnt),
    .tc    (h_tc)
  );

  raster_counter #(
    .TOTAL (V_TOT),
    .W     (COORD_W)
  ) u_v_counter (
    .clk   (CLOCK_25),
    .srst  (reset),
    .en    (h_tc),
    .count (v_cnt),
    .tc    (v_tc)
  );

  assign vga.x = h_cnt + coord_t'(1);
  assign vga.y = v_cnt + coord_t'(1);

  assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_int = in_span(h_cnt, HS_FIRST, HS_LEN);
  assign vs_int = in_span(v_cnt, VS_FIRST, VS_LEN);

  always_comb begin
    rgb_next    = vis ? vga.color : '0;
    active_next = vis;
    hsync_next  = hs_int ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_next  = vs_int ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Single pad stage: colour sampled in the same cycle as the x/y it answers.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      rgb_reg    <= '0;
      active_reg <= 1'b0;
      hsync_reg  <= ~SYNC_ACTIVE;
      vsync_reg  <= ~SYNC_ACTIVE;
    end else begin
      rgb_reg    <= rgb_next;
      active_reg <= active_next;
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
    end
  end

  assign vga.vga_r  = rgb_reg[2];
  assign vga.vga_g  = rgb_reg[1];
  assign vga.vga_b  = rgb_reg[0];
  assign vga.active = active_reg;
  assign vga.hsync  = hsync_reg;
  assign vga.vsync  = vsync_reg;

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_reg;
  logic frame_tick_next;

  assign frame_tick_next = h_tc & v_tc;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign vga.frame_tick = frame_tick_reg;
`else
  logic frame_wrap_unused;
  assign frame_wrap_unused = h_tc & v_tc;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus a shrunken,
// active-high-sync instance checked against a cycle-index raster model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int SH_A = 16, SH_F = 3, SH_S = 4, SH_B = 5;
  localparam int SV_A = 6,  SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int S_HT = SH_A + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_A + SV_F + SV_S + SV_B;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int F_HT = 800;
  localparam int F_FRAME = 420000;
  localparam int WIN = 5;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    logic pol;
  } geom_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } pads_t;

  typedef struct {
    int          edges;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] color_drv;

  int    checks = 0;
  int    errors = 0;
  int    cnt = 0;
  int    phase = 0;
  bit    rand_color = 0;
  logic [2:0] last_color = 3'b000;
  geom_t g_full;
  geom_t g_small;

  int   rgb_on = 0, hs_low = 0, fall0 = -1, fall1 = -1;
  int   hs_pulses = 0, vs_on = 0, vs_first = -1;
  logic prev_hs_full = 1'b1, prev_hs_small = 1'b0, prev_vs_small = 1'b0;

  always #20 clk = ~clk;

  vga_timing_gen_if if_full();
  vga_timing_gen_if if_small();

  assign if_full.color  = color_drv;
  assign if_small.color = color_drv;

  vga_timing_gen u_full (
    .CLOCK_25 (clk),
    .reset    (reset),
    .vga      (if_full)
  );

  vga_timing_gen #(
    .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
    .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B),
    .SYNC_ACTIVE (1'b1)
  ) u_small (
    .CLOCK_25 (clk),
    .reset    (reset),
    .vga      (if_small)
  );

  // n = clock edges since the raster last restarted; pads show position n-1.
  function automatic pads_t model(input geom_t g, input int n, input logic [2:0] col);
    int ht = g.ha + g.hf + g.hs + g.hb;
    int vt = g.va + g.vf + g.vs + g.vb;
    int ph, pv;
    bit vis;
    pads_t p;
    p.x = 12'((n % ht) + 1);
    p.y = 12'(((n / ht) % vt) + 1);
    if (n == 0) begin
      p.rgb = 3'b000; p.act = 1'b0; p.hs = ~g.pol; p.vs = ~g.pol;
    end else begin
      ph = (n - 1) % ht;
      pv = ((n - 1) / ht) % vt;
      vis = (ph < g.ha) && (pv < g.va);
      p.act = vis;
      p.rgb = vis ? col : 3'b000;
      p.hs = (ph >= g.ha + g.hf && ph < g.ha + g.hf + g.hs) ? g.pol : ~g.pol;
      p.vs = (pv >= g.va + g.vf && pv < g.va + g.vf + g.vs) ? g.pol : ~g.pol;
    end
    return p;
  endfunction

  function automatic pads_t grab_full();
    return {if_full.x, if_full.y, if_full.vga_r, if_full.vga_g, if_full.vga_b,
            if_full.hsync, if_full.vsync, if_full.active};
  endfunction

  function automatic pads_t grab_small();
    return {if_small.x, if_small.y, if_small.vga_r, if_small.vga_g, if_small.vga_b,
            if_small.hsync, if_small.vsync, if_small.active};
  endfunction

  task automatic check_pads(input string name, input pads_t got, input pads_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got x=%0d y=%0d rgb=%b hs=%b vs=%b act=%b want x=%0d y=%0d rgb=%b hs=%b vs=%b act=%b",
               name, cnt, got.x, got.y, got.rgb, got.hs, got.vs, got.act,
               want.x, want.y, want.rgb, want.hs, want.vs, want.act);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("measure %s = %0d", name, got);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got %b want %b", name, cnt, got, want);
    end
  endtask

  task automatic measure(input pads_t pf, input pads_t ps);
    if (phase == 1) begin
      if (cnt >= 1 && cnt <= F_HT) begin
        if (pf.rgb == 3'b101) rgb_on++;
        if (pf.hs == 1'b0) hs_low++;
      end
      if (prev_hs_full && !pf.hs) begin
        if (fall0 < 0) fall0 = cnt;
        else if (fall1 < 0) fall1 = cnt;
      end
    end
    if (phase == 2 && cnt > WIN * S_FRAME && cnt <= (WIN + 1) * S_FRAME) begin
      if (!prev_hs_small && ps.hs) hs_pulses++;
      if (ps.vs) vs_on++;
      if (!prev_vs_small && ps.vs && vs_first < 0) vs_first = cnt;
    end
    prev_hs_full  = pf.hs;
    prev_hs_small = ps.hs;
    prev_vs_small = ps.vs;
  endtask

  // One clock: sample on the falling edge, then present the next colour.
  task automatic step();
    logic [2:0] applied;
    logic in_reset;
    pads_t pf, ps;
    applied  = color_drv;
    in_reset = reset;
    @(posedge clk);
    @(negedge clk);
    if (in_reset) begin
      cnt = 0;
    end else begin
      cnt++;
      last_color = applied;
    end
    pf = grab_full();
    ps = grab_small();
    check_pads("full_model", pf, model(g_full, cnt, last_color));
    check_pads("small_model", ps, model(g_small, cnt, last_color));
`ifdef VGA_FRAME_TICK_EN
    check_bit("full_tick", if_full.frame_tick, (cnt > 0) && (cnt % F_FRAME == 0));
    check_bit("small_tick", if_small.frame_tick, (cnt > 0) && (cnt % S_FRAME == 0));
`endif
    measure(pf, ps);
    if (rand_color) color_drv = 3'($urandom_range(0, 7));
  endtask

  vec_t vecs[12];

  initial begin
    g_full  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    g_small = '{SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1};

    vecs[0]  = '{0,    12'd1,   12'd1, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1,    12'd2,   12'd1, 3'b101, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{640,  12'd641, 12'd1, 3'b101, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{641,  12'd642, 12'd1, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{656,  12'd657, 12'd1, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{657,  12'd658, 12'd1, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{752,  12'd753, 12'd1, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{753,  12'd754, 12'd1, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{800,  12'd1,   12'd2, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{801,  12'd2,   12'd2, 3'b101, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1457, 12'd658, 12'd2, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1600, 12'd1,   12'd3, 3'b000, 1'b1, 1'b1, 1'b0};

    reset     = 1'b1;
    color_drv = 3'b101;
    repeat (3) step();
    reset = 1'b0;

    // Directed line timing on the default-mode instance, constant colour.
    phase = 1;
    foreach (vecs[i]) begin
      while (cnt < vecs[i].edges) step();
      $display("vec %0d edge %0d x=%0d y=%0d rgb=%b hs=%b act=%b", i, cnt,
               if_full.x, if_full.y, {if_full.vga_r, if_full.vga_g, if_full.vga_b},
               if_full.hsync, if_full.active);
      check_pads($sformatf("vec%0d", i), grab_full(),
                 {vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].act});
    end
    check_int("rgb_on_line0", rgb_on, 640);
    check_int("hsync_low_width", hs_low, 96);
    check_int("hsync_first_fall", fall0, 657);
    check_int("hsync_period", fall1 - fall0, F_HT);

    // Random colours across several shrunken frames.
    phase = 2;
    rand_color = 1;
    color_drv = 3'($urandom_range(0, 7));
    while (cnt < (WIN + 1) * S_FRAME + 20) step();
    check_int("small_hs_per_frame", hs_pulses, S_VT);
    check_int("small_vs_width", vs_on, SV_S * S_HT);
    check_int("small_vs_start", vs_first, WIN * S_FRAME + (SV_A + SV_F) * S_HT + 1);

    // One-cycle reset in mid-frame of the small raster (h=10, v=4).
    phase = 3;
    while (cnt % S_FRAME != 4 * S_HT + 10) step();
    $display("mid-frame reset at n=%0d small x=%0d y=%0d", cnt, if_small.x, if_small.y);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_pads("midreset_small", grab_small(),
               {12'd1, 12'd1, 3'b000, 1'b0, 1'b0, 1'b0});
    check_pads("midreset_full", grab_full(),
               {12'd1, 12'd1, 3'b000, 1'b1, 1'b1, 1'b0});
    while (cnt < S_FRAME + 50) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
